crc16_serial_engine: RTL and testbench
======================================

Name: crc16_serial_engine

Overview:
- Parametrised successor of the byte-wide CRC16 unit in the VG93 (WD1793-compatible) controller.
- Computes CRC over a byte stream bit-serially, one bit per clock, MSB first, with a programmable polynomial, init value and sync-mark preset.
- Adds:
  - residue check for read verification;
  - byte counter with a terminal-count flag;
  - CRC append output so the write path can emit the two CRC bytes.
- Sits between the FDC data shifter and the command state machine.

Parameters:
POLY, 16'h1021, generator polynomial (x^16 term implicit).
INIT, 16'hFFFF, value loaded by iCRC_INIT.
PRESET, 16'hCDB4, value loaded by iCRC_PRESET (CRC state after INIT plus three A1 sync marks).
CNT_W, 11, byte counter width.

Ports:
iCLK  in  1  clock.
iRESET  in  1  synchronous active-high reset.
iCRC_INIT  in  1  level; load INIT, clear counter, append pointer, overrun.
iCRC_PRESET  in  1  level; load PRESET, clear counter, append pointer, overrun.
iBYTE_STB  in  1  byte strobe; rising edge accepted.
iBYTE  in  8  data byte, sampled with accepted strobe.
iAPP_REQ  in  1  append request; rising edge accepted.
iLEN  in  CNT_W  terminal count compare value.
oBUSY  out  1  shifting in progress.
oCRC  out  16  current CRC register.
oCRC_OK  out  1  oCRC==0 and not busy.
oBYTE_CNT  out  CNT_W  bytes completed.
oCNT_DONE  out  1  oBYTE_CNT==iLEN.
oAPP_BYTE  out  8  CRC byte for writing.
oAPP_VALID  out  1  one-cycle pulse; oAPP_BYTE valid.
oOVERRUN  out  1  sticky; strobe or append arrived while busy.

Behaviour:
- Reset values (iRESET=1 at a clock edge):
  - CRC=INIT, count=0, pointer=0, idle;
  - oBUSY=0, oAPP_VALID=0, oOVERRUN=0, oAPP_BYTE=8'h00;
  - edge-detect registers for iBYTE_STB and iAPP_REQ=0.
- Priority per clock: iRESET > iCRC_INIT > iCRC_PRESET > append > byte strobe.
  - INIT/PRESET mid-shift abort the byte: oBUSY=0 next cycle, counter not incremented.
- Edge detect: an event is input=1 in this cycle and 0 in the previous cycle.
  - A held level produces one event only.
- FSM states: IDLE, SHIFT.
- IDLE, strobe event:
  - latch iBYTE into the shift register;
  - bit index=7;
  - go to SHIFT; oBUSY=1 from the next cycle.
- SHIFT, each cycle:
  - fb = crc[15] ^ d[idx];
  - crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0);
  - idx decrements.
- After the 8th bit (idx==0 processed):
  - return to IDLE;
  - oBUSY=0 and oBYTE_CNT+1, both in the same cycle.
- Latency: edge sampled at cycle k → oCRC final and oBUSY low at k+9 (busy for cycles k+1..k+8).
- Counter saturates at all-ones; no wrap.
- oCNT_DONE and oCRC_OK are combinational from registers.
- Strobe or append event while in SHIFT:
  - ignored (byte dropped);
  - oOVERRUN=1 until INIT/PRESET/reset.
- Append event in IDLE:
  - next cycle oAPP_VALID=1;
  - oAPP_BYTE = pointer==0 ? crc[15:8] : crc[7:0];
  - pointer toggles (third request emits the high byte again).
  - CRC and counter are not modified by append.
  - oAPP_BYTE holds its value until the next append.
- Simultaneous strobe and append events in IDLE: append is served, the strobe is dropped, oOVERRUN=1.
- Result equals the parallel CCITT D8 engine when POLY=16'h1021.

Test Plan:
- Init, then bytes "123456789" (31..39 hex), one strobe per 12 cycles → oCRC=16'h29B1, oBYTE_CNT=9; oBUSY high exactly 8 cycles per byte.
- Init, byte 8'h00 → oCRC=16'hE1F0; append twice → oAPP_BYTE E1 then F0, each with a single oAPP_VALID pulse. Feed E1, F0 → oCRC=0, oCRC_OK=1.
- Init, bytes A1,A1,A1 → oCRC=16'hCDB4. Separately, preset → oCRC=16'hCDB4 and oBYTE_CNT=0.
- iLEN=3; feed 3 bytes → oCNT_DONE rises in the cycle oBYTE_CNT becomes 3. Hold iBYTE_STB high across 20 cycles → only one byte counted.
- Strobe at k, second strobe edge at k+4 → byte ignored, oOVERRUN=1, count+1 only. Assert iCRC_INIT at k+3 of a byte → oBUSY=0, oCRC=16'hFFFF, count 0, oOVERRUN=0.
- Set iRESET=1 during SHIFT and during an append → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/crc16_serial_engine_if.sv
// Signal bundle between the FDC data path / command FSM (master) and the CRC16 engine (slave).
// Handshake: iBYTE_STB and iAPP_REQ are consumed on their rising edge only; oAPP_VALID is a one-cycle pulse qualifying oAPP_BYTE.
interface crc16_serial_engine_if #(
  parameter int CNT_W = 11
);
  logic             iCRC_INIT;
  logic             iCRC_PRESET;
  logic             iBYTE_STB;
  logic [7:0]       iBYTE;
  logic             iAPP_REQ;
  logic [CNT_W-1:0] iLEN;
  logic             oBUSY;
  logic [15:0]      oCRC;
  logic             oCRC_OK;
  logic [CNT_W-1:0] oBYTE_CNT;
  logic             oCNT_DONE;
  logic [7:0]       oAPP_BYTE;
  logic             oAPP_VALID;
  logic             oOVERRUN;
  logic             oDBG_STATE;

  modport master (
    output iCRC_INIT, iCRC_PRESET, iBYTE_STB, iBYTE, iAPP_REQ, iLEN,
    input  oBUSY, oCRC, oCRC_OK, oBYTE_CNT, oCNT_DONE, oAPP_BYTE, oAPP_VALID, oOVERRUN, oDBG_STATE
  );

  modport slave (
    input  iCRC_INIT, iCRC_PRESET, iBYTE_STB, iBYTE, iAPP_REQ, iLEN,
    output oBUSY, oCRC, oCRC_OK, oBYTE_CNT, oCNT_DONE, oAPP_BYTE, oAPP_VALID, oOVERRUN, oDBG_STATE
  );
endinterface

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC16 engine, MSB first, with byte counter, residue check and CRC append output.
module crc16_serial_engine #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] PRESET = 16'hCDB4,
  parameter int          CNT_W  = 11
) (
  input logic                 iCLK,
  input logic                 iRESET,
  crc16_serial_engine_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       app_byte_q, app_byte_d;
  logic             app_valid_q, app_valid_d;
  logic             stb_prev_q, app_prev_q;
  logic             stb_ev, app_ev, fb;

  assign stb_ev = bus.iBYTE_STB & ~stb_prev_q;
  assign app_ev = bus.iAPP_REQ & ~app_prev_q;
  assign fb     = crc_q[15] ^ sh_q[idx_q];

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT;
      sh_q        <= 8'h00;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      ovr_q       <= 1'b0;
      app_byte_q  <= 8'h00;
      app_valid_q <= 1'b0;
      stb_prev_q  <= 1'b0;
      app_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      ovr_q       <= ovr_d;
      app_byte_q  <= app_byte_d;
      app_valid_q <= app_valid_d;
      stb_prev_q  <= bus.iBYTE_STB;
      app_prev_q  <= bus.iAPP_REQ;
    end
  end

  // Append wins over a coincident strobe, so a byte only starts when no append event is present.
  always_comb begin
    state_d = state_q;
    if (bus.iCRC_INIT || bus.iCRC_PRESET) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (stb_ev && !app_ev) state_d = S_SHIFT;
        S_SHIFT: if (idx_q == 3'd0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    crc_d       = crc_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    ovr_d       = ovr_q;
    app_byte_d  = app_byte_q;
    app_valid_d = 1'b0;
    if (bus.iCRC_INIT || bus.iCRC_PRESET) begin
      crc_d = bus.iCRC_INIT ? INIT : PRESET;
      cnt_d = '0;
      ptr_d = 1'b0;
      ovr_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      idx_d = idx_q - 3'd1;
      if (idx_q == 3'd0) cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      if (stb_ev || app_ev) ovr_d = 1'b1;
    end else if (app_ev) begin
      app_valid_d = 1'b1;
      app_byte_d  = ptr_q ? crc_q[7:0] : crc_q[15:8];
      ptr_d       = ~ptr_q;
      if (stb_ev) ovr_d = 1'b1;
    end else if (stb_ev) begin
      sh_d  = bus.iBYTE;
      idx_d = 3'd7;
    end
  end

  always_comb begin
    bus.oBUSY      = (state_q == S_SHIFT);
    bus.oCRC_OK    = (crc_q == 16'h0000) && (state_q == S_IDLE);
    bus.oDBG_STATE = state_q;
  end

  assign bus.oCRC       = crc_q;
  assign bus.oBYTE_CNT  = cnt_q;
  assign bus.oCNT_DONE  = (cnt_q == bus.iLEN);
  assign bus.oAPP_BYTE  = app_byte_q;
  assign bus.oAPP_VALID = app_valid_q;
  assign bus.oOVERRUN   = ovr_q;

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Directed bench for crc16_serial_engine; inputs change and outputs are sampled on the falling edge.
module tb_crc16_serial_engine;
  localparam int CNT_W = 11;

  logic iCLK;
  logic iRESET;
  int   checks;
  int   errors;

  crc16_serial_engine_if #(.CNT_W(CNT_W)) bus ();

  crc16_serial_engine #(
    .POLY(16'h1021), .INIT(16'hFFFF), .PRESET(16'hCDB4), .CNT_W(CNT_W)
  ) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge iCLK);
  endtask

  task automatic pulse_init();
    bus.iCRC_INIT = 1'b1;
    tick();
    bus.iCRC_INIT = 1'b0;
  endtask

  // Returns on the first idle cycle after the byte; busy length is checked when requested.
  task automatic send_byte(input logic [7:0] b, input bit chk_busy);
    int n;
    bus.iBYTE     = b;
    bus.iBYTE_STB = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    n = 0;
    while (bus.oBUSY && n < 20) begin
      n++;
      tick();
    end
    if (chk_busy || n >= 20) check("busy_len", 32'(n), 32'd8);
  endtask

  task automatic append(input logic [7:0] exp_byte);
    bus.iAPP_REQ = 1'b1;
    tick();
    check("app_valid_hi", 32'(bus.oAPP_VALID), 32'd1);
    check("app_byte", 32'(bus.oAPP_BYTE), 32'(exp_byte));
    bus.iAPP_REQ = 1'b0;
    tick();
    check("app_valid_lo", 32'(bus.oAPP_VALID), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crc"},   32'(bus.oCRC), 32'hFFFF);
    check({tag, "_cnt"},   32'(bus.oBYTE_CNT), 32'd0);
    check({tag, "_busy"},  32'(bus.oBUSY), 32'd0);
    check({tag, "_valid"}, 32'(bus.oAPP_VALID), 32'd0);
    check({tag, "_abyte"}, 32'(bus.oAPP_BYTE), 32'd0);
    check({tag, "_ovr"},   32'(bus.oOVERRUN), 32'd0);
  endtask

  logic [7:0] msg [9];

  initial begin
    checks = 0;
    errors = 0;
    iRESET          = 1'b1;
    bus.iCRC_INIT   = 1'b0;
    bus.iCRC_PRESET = 1'b0;
    bus.iBYTE_STB   = 1'b0;
    bus.iBYTE       = 8'h00;
    bus.iAPP_REQ    = 1'b0;
    bus.iLEN        = '0;
    tick(3);
    check_reset_outputs("reset");
    iRESET = 1'b0;
    tick();

    // "123456789" with standard CCITT-FALSE check value
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    pulse_init();
    for (int i = 0; i < 9; i++) begin
      send_byte(msg[i], 1'b1);
      tick(3);
    end
    check("crc_123456789", 32'(bus.oCRC), 32'h29B1);
    check("cnt_9", 32'(bus.oBYTE_CNT), 32'd9);

    // Append CRC of 00 and feed it back for a zero residue
    pulse_init();
    send_byte(8'h00, 1'b0);
    check("crc_00", 32'(bus.oCRC), 32'hE1F0);
    check("crc_ok_nonzero", 32'(bus.oCRC_OK), 32'd0);
    append(8'hE1);
    append(8'hF0);
    check("crc_held_by_append", 32'(bus.oCRC), 32'hE1F0);
    check("cnt_held_by_append", 32'(bus.oBYTE_CNT), 32'd1);
    check("abyte_holds", 32'(bus.oAPP_BYTE), 32'hF0);
    append(8'hE1);
    send_byte(8'hE1, 1'b0);
    send_byte(8'hF0, 1'b0);
    check("residue_crc", 32'(bus.oCRC), 32'h0000);
    check("residue_ok", 32'(bus.oCRC_OK), 32'd1);

    // Sync marks and preset
    pulse_init();
    for (int i = 0; i < 3; i++) send_byte(8'hA1, 1'b0);
    check("crc_a1x3", 32'(bus.oCRC), 32'hCDB4);
    pulse_init();
    send_byte(8'h55, 1'b0);
    bus.iCRC_PRESET = 1'b1;
    tick();
    bus.iCRC_PRESET = 1'b0;
    check("preset_crc", 32'(bus.oCRC), 32'hCDB4);
    check("preset_cnt", 32'(bus.oBYTE_CNT), 32'd0);

    // Terminal count and held strobe
    bus.iLEN = CNT_W'(3);
    pulse_init();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check("cnt_done_lo", 32'(bus.oCNT_DONE), 32'd0);
    send_byte(8'h56, 1'b0);
    check("cnt_3", 32'(bus.oBYTE_CNT), 32'd3);
    check("cnt_done_hi", 32'(bus.oCNT_DONE), 32'd1);
    bus.iBYTE     = 8'h78;
    bus.iBYTE_STB = 1'b1;
    tick(20);
    bus.iBYTE_STB = 1'b0;
    tick(2);
    check("held_stb_cnt", 32'(bus.oBYTE_CNT), 32'd4);
    check("held_stb_ovr", 32'(bus.oOVERRUN), 32'd0);

    // Second strobe during shift is dropped
    pulse_init();
    bus.iBYTE     = 8'h00;
    bus.iBYTE_STB = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    tick(3);
    bus.iBYTE     = 8'h55;
    bus.iBYTE_STB = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    tick(5);
    check("ovr_busy_done", 32'(bus.oBUSY), 32'd0);
    check("ovr_flag", 32'(bus.oOVERRUN), 32'd1);
    check("ovr_cnt", 32'(bus.oBYTE_CNT), 32'd1);
    check("ovr_crc", 32'(bus.oCRC), 32'hE1F0);

    // INIT mid-shift aborts the byte
    bus.iBYTE     = 8'h3C;
    bus.iBYTE_STB = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    tick(2);
    bus.iCRC_INIT = 1'b1;
    tick();
    bus.iCRC_INIT = 1'b0;
    check("abort_busy", 32'(bus.oBUSY), 32'd0);
    check("abort_crc", 32'(bus.oCRC), 32'hFFFF);
    check("abort_cnt", 32'(bus.oBYTE_CNT), 32'd0);
    check("abort_ovr", 32'(bus.oOVERRUN), 32'd0);
    tick(10);
    check("abort_cnt_later", 32'(bus.oBYTE_CNT), 32'd0);

    // Coincident append and strobe in idle
    bus.iBYTE     = 8'h99;
    bus.iBYTE_STB = 1'b1;
    bus.iAPP_REQ  = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    bus.iAPP_REQ  = 1'b0;
    check("both_valid", 32'(bus.oAPP_VALID), 32'd1);
    check("both_byte", 32'(bus.oAPP_BYTE), 32'hFF);
    check("both_busy", 32'(bus.oBUSY), 32'd0);
    check("both_ovr", 32'(bus.oOVERRUN), 32'd1);
    tick(2);
    check("both_cnt", 32'(bus.oBYTE_CNT), 32'd0);

    // Reset during shift
    send_byte(8'h11, 1'b0);
    bus.iBYTE     = 8'h22;
    bus.iBYTE_STB = 1'b1;
    tick();
    bus.iBYTE_STB = 1'b0;
    tick(2);
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    check_reset_outputs("rst_shift");

    // Reset coincident with an append request
    append(8'hFF);
    tick();
    iRESET       = 1'b1;
    bus.iAPP_REQ = 1'b1;
    tick();
    iRESET       = 1'b0;
    bus.iAPP_REQ = 1'b0;
    check_reset_outputs("rst_app");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
